// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - instruction handshake bundle for writeback_unit
// Purpose: carries one decoded instruction from the execute stage into the
//   writeback unit, with a valid/ready handshake.
// Signals:
//   in_valid, in_ready         handshake (ready driven by the writeback unit)
//   in_alu_result, in_mem_read write-data candidates; alu result is also the
//                              absolute branch target
//   in_wb_src, in_rf_we, in_rd register-file write control
//   in_flags, in_flag_we       new {N,Z,V} flags and per-bit write mask
//   in_is_branch, in_br_cond,
//   in_br_rel, in_br_offset    branch control
//   in_halt                    HLT instruction
// Modports: master = instruction producer, slave = writeback unit.
interface writeback_unit_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_mem_read;
  logic              in_wb_src;
  logic              in_rf_we;
  logic [REG_AW-1:0] in_rd;
  logic [2:0]        in_flags;
  logic [2:0]        in_flag_we;
  logic              in_is_branch;
  logic [2:0]        in_br_cond;
  logic              in_br_rel;
  logic [DATA_W-1:0] in_br_offset;
  logic              in_halt;

  modport master (
    output in_valid, in_alu_result, in_mem_read, in_wb_src, in_rf_we, in_rd,
           in_flags, in_flag_we, in_is_branch, in_br_cond, in_br_rel,
           in_br_offset, in_halt,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_alu_result, in_mem_read, in_wb_src, in_rf_we, in_rd,
           in_flags, in_flag_we, in_is_branch, in_br_cond, in_br_rel,
           in_br_offset, in_halt,
    output in_ready
  );
endinterface

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - writeback stage: register write, flags, PC and branch redirect
// Purpose: commits one instruction per accepted handshake: registered
//   register-file write, flag update, PC advance or branch redirect, and HLT.
// Ports:
//   clk, rst_n    clock and synchronous active-low reset
//   ins           instruction handshake bundle (slave side)
//   stall         downstream hold request; blocks acceptance
//   pc, flags     architectural PC and {N,Z,V} flag registers
//   rf_we, rf_waddr, rf_wdata   registered register-file write port
//   redirect, redirect_pc       one-cycle taken-branch pulse and its target
//   halted        unit is in the HALT state
module writeback_unit #(
  parameter int DATA_W      = 16,
  parameter int REG_AW      = 4,
  parameter int INSTR_BYTES = 2,
  parameter int RESET_PC    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  writeback_unit_if.slave   ins,
  input  logic              stall,
  output logic [DATA_W-1:0] pc,
  output logic [2:0]        flags,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              halted
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [2:0]        flags_q, flags_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              redirect_q, redirect_d;
  logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;

  logic              accept;
  logic              cond_true;
  logic              taken;
  logic [DATA_W-1:0] pc_seq;
  logic [DATA_W-1:0] target;
  logic              flag_n, flag_z, flag_v;

  assign ins.in_ready = !stall && (state_q == RUN);
  assign accept       = ins.in_valid && ins.in_ready;

  // Conditions look at the flags as they stood before this instruction,
  // so an instruction that both sets flags and branches sees the old values.
  assign flag_n = flags_q[2];
  assign flag_z = flags_q[1];
  assign flag_v = flags_q[0];

  always_comb begin
    cond_true = 1'b0;
    case (ins.in_br_cond)
      3'b000: cond_true = !flag_z;
      3'b001: cond_true = flag_z;
      3'b010: cond_true = !flag_z && !flag_n;
      3'b011: cond_true = flag_n;
      3'b100: cond_true = flag_z || (!flag_z && !flag_n);
      3'b101: cond_true = flag_n || flag_z;
      3'b110: cond_true = flag_v;
      3'b111: cond_true = 1'b1;
    endcase
  end

  // PC arithmetic truncates to DATA_W bits, so wrap-around is implicit.
  assign pc_seq = pc_q + DATA_W'(INSTR_BYTES);
  assign target = ins.in_br_rel ? (pc_seq + ins.in_br_offset) : ins.in_alu_result;
  assign taken  = accept && ins.in_is_branch && !ins.in_halt && cond_true;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    flags_d       = flags_q;
    rf_we_d       = 1'b0;
    rf_waddr_d    = rf_waddr_q;
    rf_wdata_d    = rf_wdata_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;

    if (accept) begin
      rf_we_d    = ins.in_rf_we && !ins.in_halt;
      rf_waddr_d = ins.in_rd;
      rf_wdata_d = ins.in_wb_src ? ins.in_mem_read : ins.in_alu_result;
      flags_d    = (ins.in_flags & ins.in_flag_we) | (flags_q & ~ins.in_flag_we);

      if (ins.in_halt) begin
        state_d = HALT;
      end else if (taken) begin
        pc_d          = target;
        redirect_d    = 1'b1;
        redirect_pc_d = target;
      end else begin
        pc_d = pc_seq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= DATA_W'(RESET_PC);
      flags_q       <= 3'b000;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      flags_q       <= flags_d;
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign pc          = pc_q;
  assign flags       = flags_q;
  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign halted      = (state_q == HALT);

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, giving the data and PC width in bits.
REQ-002 The module SHALL have parameter REG_AW, default 4, giving the register-file address width.
REQ-003 The module SHALL have parameter INSTR_BYTES, default 2, giving the sequential PC increment.
REQ-004 The module SHALL have parameter RESET_PC, default 0, giving the PC value after reset.
REQ-005 The module SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  unit accepts the instruction this cycle.
- in_alu_result  in  DATA_W  ALU result; also the absolute branch target.
- in_mem_read  in  DATA_W  memory load data.
- in_wb_src  in  1  write-data source: 0 = ALU, 1 = MEM.
- in_rf_we  in  1  instruction writes the register file.
- in_rd  in  REG_AW  destination register.
- in_flags  in  3  new flags {N,Z,V}.
- in_flag_we  in  3  per-flag write mask {N,Z,V}.
- in_is_branch  in  1  instruction is a branch.
- in_br_cond  in  3  branch condition code.
- in_br_rel  in  1  branch target mode: 1 = relative, 0 = absolute.
- in_br_offset  in  DATA_W  relative branch offset, two's complement.
- in_halt  in  1  instruction is HLT.
- stall  in  1  downstream hold request.
- pc  out  DATA_W  architectural PC register.
- flags  out  3  architectural flag register {N,Z,V}.
- rf_we, rf_waddr, rf_wdata  out  1 / REG_AW / DATA_W  registered register-file write port.
- redirect  out  1  one-cycle pulse indicating a taken branch.
- redirect_pc  out  DATA_W  branch target, valid while redirect = 1.
- halted  out  1  unit is in the HALT state.

Function
REQ-006 Accept SHALL equal in_valid & in_ready; in_ready SHALL equal !stall & (state == RUN), combinationally.
REQ-007 The state machine SHALL have two states, RUN and HALT: RUN -> HALT on an accept with in_halt = 1; HALT SHALL hold until reset.
REQ-008 On an accept, rf_we <= in_rf_we & !in_halt, rf_waddr <= in_rd, and rf_wdata <= (in_wb_src ? in_mem_read : in_alu_result), giving one cycle of latency.
REQ-009 On a cycle without an accept, rf_we SHALL be 0 next cycle, and rf_waddr and rf_wdata SHALL hold their values.
REQ-010 On an accept, each flag bit i SHALL load in_flags[i] if in_flag_we[i] = 1 and otherwise hold.
REQ-011 Branch evaluation SHALL use the registered flags from before this instruction's own flag update.
REQ-012 Condition codes SHALL be:
- 000 Z=0
- 001 Z=1
- 010 Z=0 and N=0
- 011 N=1
- 100 Z=1 or (Z=0 and N=0)
- 101 N=1 or Z=1
- 110 V=1
- 111 always
REQ-013 Taken SHALL equal accept & in_is_branch & !in_halt & cond_true.
REQ-014 The branch target SHALL be in_br_rel ? (pc + INSTR_BYTES + in_br_offset) : in_alu_result.
REQ-015 All PC arithmetic SHALL be modulo 2^DATA_W; wrap-around is silent.
REQ-016 On an accept, the pc update SHALL be:
- taken: pc <= target.
- HLT: pc holds.
- otherwise: pc <= pc + INSTR_BYTES.
REQ-017 Without an accept, pc SHALL hold.
REQ-018 On a taken branch, redirect SHALL be 1 and redirect_pc SHALL equal the target in the following cycle only.
- Otherwise redirect SHALL be 0 and redirect_pc SHALL hold its value.
REQ-019 If stall and in_valid are both high, nothing SHALL update, and the instruction SHALL be presented again in a later cycle.
REQ-020 A branch that also writes a register SHALL perform both the register write and the PC redirect.
REQ-021 halted SHALL equal (state == HALT) as a registered output.

Reset
REQ-022 While rst_n = 0 at a clock edge, the module SHALL set:
- state = RUN, pc = RESET_PC, flags = 000.
- rf_we = 0, rf_waddr = 0, rf_wdata = 0.
- redirect = 0, redirect_pc = 0, halted = 0.
REQ-023 Reset SHALL override any same-cycle accept, including one arriving in HALT or mid-stall; the first accept SHALL be possible in the cycle after rst_n rises.

Verification
REQ-024 Case: reset, then three accepts of non-branch ALU writes (rd = 1, 2, 3) -> pc = 0, 2, 4, 6, and rf_we pulses one cycle after each accept carrying the matching rd and data.
REQ-025 Case: flags = 000 (Z=0); accept a branch with cond 000, br_rel = 1, offset 0x0010, at pc = 0x0004 -> next cycle redirect = 1, redirect_pc = 0x0016, pc = 0x0016.
REQ-026 Case: a single instruction with flag_we = 010, in_flags = 010, and a cond-001 branch at flags = 000 -> branch not taken (old Z used), Z becomes 1, pc += 2.
REQ-027 Case: pc = 0xFFFE with a non-branch accept -> pc = 0x0000; with an absolute branch where alu_result = 0xFFFF -> pc = 0xFFFF.
REQ-028 Case: hold stall = 1 with in_valid = 1 for 3 cycles -> in_ready = 0, and pc, flags and rf_we stay unchanged; release stall -> one accept.
REQ-029 Case: accept HLT with rf_we = 1 -> halted = 1, in_ready = 0, rf_we = 0, pc frozen; assert rst_n = 0 for one cycle -> all outputs return to their reset values.
